// File: rtl/ser_pkg.sv
// ser_pkg: shared state encoding and counter sizing for the PISO serializer
package ser_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} ser_state_t;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake and serial stream bundle; SER_PARITY_EN adds PAR_TYP
interface piso_serializer_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic data_valid;
  logic load_ready;
  logic ser_en;
  logic ser_data;
  logic ser_done;
  logic busy;
`ifdef SER_PARITY_EN
  logic PAR_TYP;
  modport master (output P_DATA, data_valid, ser_en, PAR_TYP, input load_ready, ser_data, ser_done, busy);
  modport slave (input P_DATA, data_valid, ser_en, PAR_TYP, output load_ready, ser_data, ser_done, busy);
`else
  modport master (output P_DATA, data_valid, ser_en, input load_ready, ser_data, ser_done, busy);
  modport slave (input P_DATA, data_valid, ser_en, output load_ready, ser_data, ser_done, busy);
`endif
endinterface

// File: rtl/ser_parity_calc.sv
// ser_parity_calc: even (odd=0) or odd (odd=1) parity of a word
module ser_parity_calc #(parameter int DATA_WIDTH = 8) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  odd,
  output logic                  parity
);
  assign parity = ^data ^ odd;
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready loaded PISO shifter for UART TX; SER_PARITY_EN appends a parity bit
module piso_serializer
  import ser_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input logic              CLK,
  input logic              RST,
  piso_serializer_if.slave sif
);
  localparam int CW = cnt_w(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  ser_state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ser_data_q, ser_data_d, ser_done_q, ser_done_d;
`ifdef SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  logic par_in, par_q, par_d;
  ser_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (.data(sif.P_DATA), .odd(sif.PAR_TYP), .parity(par_in));
`else
  localparam bit PAR_EN = 1'b0;
`endif
  assign sif.load_ready = state_q == IDLE;
  assign sif.busy       = state_q != IDLE;
  assign sif.ser_data   = ser_data_q;
  assign sif.ser_done   = ser_done_q;
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    ser_data_d = ser_data_q;
    ser_done_d = 1'b0;
`ifdef SER_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        ser_data_d = IDLE_LEVEL;
        if (sif.data_valid) begin
          state_d = SHIFT;
          shreg_d = sif.P_DATA;
          cnt_d   = '0;
`ifdef SER_PARITY_EN
          par_d   = par_in;
`endif
        end
      end
      SHIFT: if (sif.ser_en) begin
        ser_data_d = MSB_FIRST ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
        shreg_d    = MSB_FIRST ? {shreg_q[DATA_WIDTH-2:0], 1'b0} : {1'b0, shreg_q[DATA_WIDTH-1:1]};
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d    = PAR_EN ? PARITY : IDLE;
          ser_done_d = !PAR_EN;
        end
      end
`ifdef SER_PARITY_EN
      PARITY: if (sif.ser_en) begin
        ser_data_d = par_q;
        ser_done_d = 1'b1;
        state_d    = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      ser_data_q <= IDLE_LEVEL;
      ser_done_q <= 1'b0;
`ifdef SER_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      ser_data_q <= ser_data_d;
      ser_done_q <= ser_done_d;
`ifdef SER_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of four serializer builds (8 LSB, 8 MSB, 5 LSB, 16 LSB)
module tb_piso_serializer;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic dv[4], en[4];
  logic [15:0] pd[4];
  logic par_typ;
  logic sd[4], dn[4], bz[4], rd[4];
  int total = 0;
  int bad = 0;
`ifdef SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  always #5 CLK = ~CLK;
  piso_serializer_if #(.DATA_WIDTH(8))  i0 ();
  piso_serializer_if #(.DATA_WIDTH(8))  i1 ();
  piso_serializer_if #(.DATA_WIDTH(5))  i2 ();
  piso_serializer_if #(.DATA_WIDTH(16)) i3 ();
  assign i0.P_DATA = pd[0][7:0];
  assign i1.P_DATA = pd[1][7:0];
  assign i2.P_DATA = pd[2][4:0];
  assign i3.P_DATA = pd[3];
  assign i0.data_valid = dv[0];
  assign i1.data_valid = dv[1];
  assign i2.data_valid = dv[2];
  assign i3.data_valid = dv[3];
  assign i0.ser_en = en[0];
  assign i1.ser_en = en[1];
  assign i2.ser_en = en[2];
  assign i3.ser_en = en[3];
`ifdef SER_PARITY_EN
  assign i0.PAR_TYP = par_typ;
  assign i1.PAR_TYP = par_typ;
  assign i2.PAR_TYP = par_typ;
  assign i3.PAR_TYP = par_typ;
`endif
  assign sd[0] = i0.ser_data;
  assign sd[1] = i1.ser_data;
  assign sd[2] = i2.ser_data;
  assign sd[3] = i3.ser_data;
  assign dn[0] = i0.ser_done;
  assign dn[1] = i1.ser_done;
  assign dn[2] = i2.ser_done;
  assign dn[3] = i3.ser_done;
  assign bz[0] = i0.busy;
  assign bz[1] = i1.busy;
  assign bz[2] = i2.busy;
  assign bz[3] = i3.busy;
  assign rd[0] = i0.load_ready;
  assign rd[1] = i1.load_ready;
  assign rd[2] = i2.load_ready;
  assign rd[3] = i3.load_ready;
  piso_serializer #(.DATA_WIDTH(8))                    u0 (.CLK(CLK), .RST(RST), .sif(i0.slave));
  piso_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u1 (.CLK(CLK), .RST(RST), .sif(i1.slave));
  piso_serializer #(.DATA_WIDTH(5))                    u2 (.CLK(CLK), .RST(RST), .sif(i2.slave));
  piso_serializer #(.DATA_WIDTH(16))                   u3 (.CLK(CLK), .RST(RST), .sif(i3.slave));
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic accept(input int k, input logic [15:0] v);
    pd[k] = v;
    dv[k] = 1'b1;
    en[k] = 1'b1;
    tick;
    chk($sformatf("k%0d accept_busy", k), 16'(bz[k]), 16'd1);
    chk($sformatf("k%0d accept_ready", k), 16'(rd[k]), 16'd0);
    chk($sformatf("k%0d accept_en_ignored", k), 16'(sd[k]), 16'd1);
  endtask
  task automatic shift(input int k, input int w, input bit msb, input logic [15:0] v, input bit gap);
    logic prev = 1'b1;
    logic b;
    logic p = par_typ;
    for (int i = 0; i < w; i++) begin
      if (gap && i % 2 == 1) begin
        en[k] = 1'b0;
        tick;
        chk($sformatf("k%0d gap_hold%0d", k, i), 16'(sd[k]), 16'(prev));
        chk($sformatf("k%0d gap_done%0d", k, i), 16'(dn[k]), 16'd0);
        en[k] = 1'b1;
      end
      tick;
      b = msb ? v[w-1-i] : v[i];
      p ^= v[i];
      chk($sformatf("k%0d bit%0d", k, i), 16'(sd[k]), 16'(b));
      chk($sformatf("k%0d done%0d", k, i), 16'(dn[k]), 16'(i == w - 1 && !PAR));
      prev = b;
    end
    if (PAR) begin
      tick;
      chk($sformatf("k%0d parity_bit", k), 16'(sd[k]), 16'(p));
      chk($sformatf("k%0d parity_done", k), 16'(dn[k]), 16'd1);
    end
  endtask
  task automatic idle_chk(input int k);
    tick;
    chk($sformatf("k%0d idle_data", k), 16'(sd[k]), 16'd1);
    chk($sformatf("k%0d idle_done", k), 16'(dn[k]), 16'd0);
    chk($sformatf("k%0d idle_ready", k), 16'(rd[k]), 16'd1);
    chk($sformatf("k%0d idle_busy", k), 16'(bz[k]), 16'd0);
  endtask
  task automatic send(input int k, input int w, input bit msb, input logic [15:0] v, input bit gap);
    accept(k, v);
    dv[k] = 1'b0;
    shift(k, w, msb, v, gap);
    en[k] = 1'b0;
    idle_chk(k);
  endtask
  initial begin
    for (int k = 0; k < 4; k++) begin
      dv[k] = 1'b0;
      en[k] = 1'b0;
      pd[k] = '0;
    end
    par_typ = 1'b0;
    repeat (2) tick;
    chk("reset_data", 16'(sd[0]), 16'd1);
    chk("reset_busy", 16'(bz[0]), 16'd0);
    chk("reset_done", 16'(dn[0]), 16'd0);
    RST = 1'b1;
    tick;
    chk("release_ready", 16'(rd[0]), 16'd1);
    send(0, 8, 1'b0, 16'h00C1, 1'b0);
    send(1, 8, 1'b1, 16'h00C1, 1'b0);
    send(0, 8, 1'b0, 16'h00C1, 1'b1);
    accept(0, 16'h00C1);
    pd[0] = 16'h003C;
    shift(0, 8, 1'b0, 16'h00C1, 1'b0);
    chk("held_valid_ready_after_done", 16'(rd[0]), 16'd1);
    accept(0, 16'h003C);
    dv[0] = 1'b0;
    shift(0, 8, 1'b0, 16'h003C, 1'b0);
    en[0] = 1'b0;
    idle_chk(0);
    accept(0, 16'h00C1);
    dv[0] = 1'b0;
    repeat (3) tick;
    chk("pre_reset_bit2", 16'(sd[0]), 16'd0);
    #2 RST = 1'b0;
    #1;
    chk("abort_data", 16'(sd[0]), 16'd1);
    chk("abort_busy", 16'(bz[0]), 16'd0);
    chk("abort_done", 16'(dn[0]), 16'd0);
    en[0] = 1'b0;
    tick;
    RST = 1'b1;
    tick;
    chk("abort_release_ready", 16'(rd[0]), 16'd1);
    send(0, 8, 1'b0, 16'h005A, 1'b0);
    send(2, 5, 1'b0, 16'h0013, 1'b0);
    send(3, 16, 1'b0, 16'hA5C3, 1'b0);
    par_typ = 1'b1;
    send(0, 8, 1'b0, 16'h00C1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
